// File: rtl/aes_stream_adapter.sv
// 32-bit valid/ready word-stream front/back end for the 128-bit AES encrypt core.
// Optional key reuse (skip the key phase) with `define AES_STREAM_ADAPTER_KEY_REUSE_EN.
module aes_stream_adapter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_is_key,
  output logic         core_start,
  output logic [127:0] core_plain_text,
  output logic [127:0] core_key,
  input  logic [127:0] core_cipher_text,
  input  logic         core_finish,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned TMO_W  = 8;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [2:0]              word_cnt;
  logic [TMO_W-1:0]        wait_cnt;
  logic [BLK_W-WORD_W-1:0] out_buf;
  logic [1:0]              out_idx;
  logic                    in_acc;
  logic                    out_acc;
  logic                    key_skip;
  logic                    ct_cap;
  logic                    wait_tmo;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

`ifdef AES_STREAM_ADAPTER_KEY_REUSE_EN
  logic key_valid;

  // A stored key becomes reusable once all four key words have been loaded
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_valid <= 1'b0;
    end else if (state == S_LOAD && in_acc && !key_skip && word_cnt == 3'd3) begin
      key_valid <= 1'b1;
    end
  end

  assign key_skip = (word_cnt == 3'd0) & key_valid & ~in_is_key;
`else
  logic unused_in_is_key;
  assign unused_in_is_key = in_is_key;
  assign key_skip         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; timeout fires on the edge where the wait counter reaches TIMEOUT-1,
  // so err is visible TIMEOUT cycles after the start pulse.
  always_comb begin
    state_nxt = state;
    ct_cap    = 1'b0;
    wait_tmo  = 1'b0;
    case (state)
      S_LOAD:  if (in_acc && word_cnt == 3'd7) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_finish) begin
          state_nxt = S_OUT;
          ct_cap    = 1'b1;
        end else if (wait_cnt == TMO_W'(TIMEOUT - 2)) begin
          state_nxt = S_LOAD;
          wait_tmo  = 1'b1;
        end
      end
      S_OUT:   if (out_acc && out_idx == 2'd3) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Registered handshake/status outputs follow the next state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      in_ready   <= (state_nxt == S_LOAD);
      busy       <= (state_nxt != S_LOAD);
      core_start <= (state_nxt == S_START);
      out_valid  <= (state_nxt == S_OUT);
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + TMO_W'(1) : '0;
      if (wait_tmo) err <= 1'b1;
    end
  end

  // Operand assembly: key and plaintext shift in MSW first, held until the next load
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      word_cnt        <= '0;
      core_key        <= '0;
      core_plain_text <= '0;
    end else if (state == S_LOAD && in_acc) begin
      if (key_skip || word_cnt[2]) begin
        core_plain_text <= {core_plain_text[BLK_W-WORD_W-1:0], in_data};
      end else begin
        core_key <= {core_key[BLK_W-WORD_W-1:0], in_data};
      end
      word_cnt <= key_skip ? 3'd5 : word_cnt + 3'd1;
    end
  end

  // Ciphertext buffer: out_data holds the current word, out_buf the remaining ones
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_data <= '0;
      out_last <= 1'b0;
      out_buf  <= '0;
      out_idx  <= '0;
    end else if (ct_cap) begin
      out_data <= core_cipher_text[BLK_W-1 -: WORD_W];
      out_buf  <= core_cipher_text[BLK_W-WORD_W-1:0];
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (state == S_OUT && out_acc && out_idx != 2'd3) begin
      out_data <= out_buf[BLK_W-WORD_W-1 -: WORD_W];
      out_buf  <= {out_buf[BLK_W-2*WORD_W-1:0], WORD_W'(0)};
      out_idx  <= out_idx + 2'd1;
      out_last <= (out_idx == 2'd2);
    end
  end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Scoreboard bench for aes_stream_adapter with a stub encrypt core (finish 13 cycles after start).
module tb_aes_stream_adapter;

  localparam int unsigned TMO = 20;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P2  = 128'hffffffff00000000aaaaaaaa55555555;
  // Stub core returns key^pt for non-C.1 operands
  localparam logic [127:0] C2  = 128'hfedcba9889abcdef5476103223016745;

  logic         clk = 1'b0;
  logic         nrst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_is_key;
  logic         core_start;
  logic [127:0] core_plain_text;
  logic [127:0] core_key;
  logic [127:0] core_cipher_text;
  logic         core_finish;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int xfer_cnt = 0;
  logic core_dead = 1'b0;
  logic [32:0] exp_q[$];

  aes_stream_adapter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_is_key(in_is_key),
    .core_start(core_start), .core_plain_text(core_plain_text), .core_key(core_key),
    .core_cipher_text(core_cipher_text), .core_finish(core_finish),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] stub_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == C1K && p == C1P) return C1C;
    return k ^ p;
  endfunction

  // Stub core: finish (level) rises 13 cycles after the start cycle, drops on next start
  logic [3:0] core_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_finish      <= 1'b0;
      core_cnt         <= '0;
      core_cipher_text <= '0;
    end else if (core_start) begin
      core_finish <= 1'b0;
      core_cnt    <= 4'd12;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 4'd1;
      if (core_cnt == 4'd1 && !core_dead) begin
        core_finish      <= 1'b1;
        core_cipher_text <= stub_ct(core_key, core_plain_text);
      end
    end
  end

  // Monitor: scoreboard pops, latency, backpressure stability, in_ready after last word
  logic        ov_prev = 1'b0;
  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_l;
  logic        rdy_pending = 1'b0;
  always @(negedge clk) begin
    if (!nrst) begin
      ov_prev     = 1'b0;
      held_v      = 1'b0;
      rdy_pending = 1'b0;
    end else begin
      if (rdy_pending) begin
        check("in_ready_after_last", {127'd0, in_ready}, 128'd1);
        rdy_pending = 1'b0;
      end
      if (core_start) start_cyc = cyc;
      if (out_valid && !ov_prev) check("latency", 128'(cyc - start_cyc), 128'd14);
      if (held_v) begin
        check("hold_valid", {127'd0, out_valid}, 128'd1);
        check("hold_data", {96'd0, out_data}, {96'd0, held_d});
        check("hold_last", {127'd0, out_last}, {127'd0, held_l});
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {96'd0, out_data}, 128'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("out_data", {96'd0, out_data}, {96'd0, e[31:0]});
          check("out_last", {127'd0, out_last}, {127'd0, e[32]});
        end
        if (out_last) rdy_pending = 1'b1;
      end
      ov_prev = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic k);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = w;
    in_is_key = k;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 128'd0, 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [127:0] c);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), c[127 - 32*i -: 32]});
  endtask

  task automatic send_frame(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c,
                            input bit push, input bit gaps, input int nwords, input bit ktag);
    if (push) push_exp(c);
    for (int i = 0; i < nwords; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step();
      if (i < 4) send_word(k[127 - 32*i -: 32], ktag);
      else       send_word(p[127 - 32*(i-4) -: 32], 1'b0);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("start_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("idle_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_core_start", {127'd0, core_start}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_last", {127'd0, out_last}, 128'd0);
    check("rst_out_data", {96'd0, out_data}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_core_pt", core_plain_text, 128'd0);
  endtask

  initial begin
    int base;
    logic saw_ov;
    nrst = 1'b0; in_valid = 1'b0; in_data = '0; in_is_key = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    nrst = 1'b1;
    step();

    // C.1 frame, then stray in_valid during WAIT
    send_frame(C1K, C1P, C1C, 1'b1, 1'b0, 8, 1'b1);
    wait_start();
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    for (int i = 0; i < 6; i++) begin
      check("in_ready_busy", {127'd0, in_ready}, 128'd0);
      check("busy_high", {127'd0, busy}, 128'd1);
      step();
    end
    in_valid = 1'b0;
    wait_idle();

    // Gapped input frame; stale finish from the previous block is present during START
    send_frame(K2, P2, C2, 1'b1, 1'b1, 8, 1'b1);
    wait_idle();

    // Output backpressure
    out_ready = 1'b0;
    base = xfer_cnt;
    send_frame(C1K, C1P, C1C, 1'b1, 1'b0, 8, 1'b1);
    for (int n = 0; n < 100 && !out_valid; n++) step();
    repeat (5) step();
    for (int n = 0; n < 40 && xfer_cnt < base + 4; n++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    check("xfer_count", 128'(xfer_cnt - base), 128'd4);
    wait_idle();

    // Timeout with a dead core
    core_dead = 1'b1;
    send_frame(C1K, C1P, C1C, 1'b0, 1'b0, 8, 1'b1);
    wait_start();
    saw_ov = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step();
      saw_ov |= out_valid;
    end
    check("err_before_tmo", {127'd0, err}, 128'd0);
    step();
    saw_ov |= out_valid;
    check("err_at_tmo", {127'd0, err}, 128'd1);
    check("tmo_in_ready", {127'd0, in_ready}, 128'd1);
    check("tmo_busy", {127'd0, busy}, 128'd0);
    check("tmo_no_out", {127'd0, saw_ov}, 128'd0);
    core_dead = 1'b0;
    repeat (2) step();

    // Good block after timeout; err is sticky
    send_frame(K2, P2, C2, 1'b1, 1'b0, 8, 1'b1);
    wait_idle();
    check("err_sticky", {127'd0, err}, 128'd1);

    // Reset after 5 input words, then a clean C.1 frame
    send_frame(C1K, C1P, C1C, 1'b0, 1'b0, 5, 1'b1);
    nrst = 1'b0;
    #1;
    check_reset_vals();
    step();
    nrst = 1'b1;
    step();
    send_frame(C1K, C1P, C1C, 1'b1, 1'b0, 8, 1'b1);
    wait_idle();

`ifdef AES_STREAM_ADAPTER_KEY_REUSE_EN
    // Plaintext-only frame reuses the stored C.1 key
    push_exp(C1C);
    for (int i = 0; i < 4; i++) send_word(C1P[127 - 32*i -: 32], 1'b0);
    wait_idle();
    // After reset no key is stored: untagged first words load as key
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    step();
    send_frame(C1K, C1P, C1C, 1'b1, 1'b0, 8, 1'b0);
    wait_idle();
    check("reuse_key_loaded", core_key, C1K);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
